// File: rtl/osc_div_pkg.sv
// Shared timebase constants for the oscillator tick divider.
// half_for_hz() turns a target sq_out frequency into a half-period.
package osc_div_pkg;

  localparam int OSC_HZ       = 48_000_000;
  localparam int DIV_W        = 24;
  localparam int CNT_W        = 8;
  localparam int DEFAULT_HALF = 10_000_000;

  function automatic int half_for_hz(input int hz);
    return OSC_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/osc_tick_divider_if.sv
// Control and output bundle of the tick divider.
// The master drives en/load/half_period, the divider returns the outputs.
interface osc_tick_divider_if
  import osc_div_pkg::*;
#(
  parameter int DIV_W = osc_div_pkg::DIV_W,
  parameter int CNT_W = osc_div_pkg::CNT_W
);

  logic             en;
  logic             load;
  logic [DIV_W-1:0] half_period;
  logic             tick;
  logic             sq_out;
  logic [CNT_W-1:0] toggles;

  modport master (
    output en,
    output load,
    output half_period,
    input  tick,
    input  sq_out,
    input  toggles
  );

  modport slave (
    input  en,
    input  load,
    input  half_period,
    output tick,
    output sq_out,
    output toggles
  );

endinterface

// File: rtl/osc_tick_divider.sv
// Programmable divider of the HF oscillator clock into a one-cycle tick
// and a 50% square wave; half-period counted in enabled cycles only.
module osc_tick_divider
  import osc_div_pkg::*;
#(
  parameter int DIV_W        = osc_div_pkg::DIV_W,
  parameter int DEFAULT_HALF = osc_div_pkg::DEFAULT_HALF,
  parameter int CNT_W        = osc_div_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  osc_tick_divider_if.slave   bus
);

  localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(DEFAULT_HALF);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] half_reg;
  logic [DIV_W-1:0] half_new;
  logic             tick_q;
  logic             sq_q;
  logic [CNT_W-1:0] tog_q;
  logic             term;

  // A zero half-period would never match; clamp it to the fastest rate.
  assign half_new = (bus.half_period == '0) ? ONE : bus.half_period;
  assign term     = (count == half_reg - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      half_reg <= DEF_HALF;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
      tog_q    <= '0;
    end else if (bus.load) begin
      half_reg <= half_new;
      count    <= '0;
      tog_q    <= '0;
      tick_q   <= 1'b0;
    end else if (bus.en) begin
      if (term) begin
        count  <= '0;
        tick_q <= 1'b1;
        sq_q   <= ~sq_q;
        tog_q  <= tog_q + CNT_W'(1);
      end else begin
        count  <= count + ONE;
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.sq_out  = sq_q;
  assign bus.toggles = tog_q;

endmodule
